// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the data-memory access stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
  typedef enum logic [1:0] {WidthB, WidthH, WidthW} width_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam int unsigned WaitMaxDefault = 15;

  // Unused funct3 codes fall through to word width.
  function automatic width_e f3_width(input logic [2:0] f3);
    case (f3)
      F3Byte, F3ByteU: return WidthB;
      F3Half, F3HalfU: return WidthH;
      F3Word:          return WidthW;
      default:         return WidthW;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    width_e w;
    w = f3_width(f3);
    return ((w == WidthH) && lo[0]) || ((w == WidthW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Store lane replication / byte enables and load lane select with sign or zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  width_e      width;
  logic        sign_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign width    = f3_width(funct3_i);
  assign sign_ext = ~funct3_i[2];
  assign ld_b     = ld_word_i[{addr_lo_i, 3'b000} +: 8];
  assign ld_h     = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = ld_word_i;
    unique case (width)
      WidthB: begin
        st_be_o   = 4'b0001 << addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_ext & ld_b[7]}}, ld_b};
      end
      WidthH: begin
        st_be_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sign_ext & ld_h[15]}}, ld_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle load/store stage with req/ack memory port and stall generation.
// Optional misalignment trap: define MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WaitMaxDefault
) (
  input  logic        clk,
  input  logic        INT,
  input  logic [31:0] z,
  input  logic [31:0] rd2,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] memOut,
  output logic        stall,
  output logic        err,
  output logic        misalign,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mbe,
  input  logic [31:0] mrdata,
  input  logic        mack
);

  localparam int unsigned   CntW    = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic [31:0]     maddr_q, maddr_d;
  logic [31:0]     mwdata_q, mwdata_d;
  logic [3:0]      mbe_q, mbe_d;
  logic [31:0]     memout_q, memout_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic        access, in_idle, trap;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  assign access  = MemRead | MemWrite;
  assign in_idle = (state_q == StIdle);

  // Store lanes come from live EX inputs at capture; load lanes from the captured access.
  assign align_f3 = in_idle ? funct3 : f3_q;
  assign align_lo = in_idle ? z[1:0] : lo_q;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap = is_misaligned(funct3, z[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_align (
    .funct3_i  (align_f3),
    .addr_lo_i (align_lo),
    .st_data_i (rd2),
    .ld_word_i (mrdata),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    memout_d = memout_q;
    err_d    = 1'b0;
    mis_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          we_d     = MemWrite;
          f3_d     = funct3;
          lo_d     = z[1:0];
          maddr_d  = {z[31:2], 2'b00};
          mwdata_d = MemWrite ? st_data : 32'd0;
          mbe_d    = MemWrite ? st_be : 4'b1111;
          cnt_d    = '0;
          if (trap) begin
            state_d  = StDone;
            mis_d    = 1'b1;
            memout_d = 32'd0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mack) begin
          if (!we_q) memout_d = ld_data;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          state_d  = StDone;
          err_d    = 1'b1;
          memout_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (INT) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      mbe_q    <= 4'd0;
      memout_q <= 32'd0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      memout_q <= memout_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  assign mreq     = (state_q == StReq);
  assign mwe      = mreq & we_q;
  assign stall    = ~INT & ((in_idle & access) | mreq);
  assign maddr    = maddr_q;
  assign mwdata   = mwdata_q;
  assign mbe      = mbe_q;
  assign memOut   = memout_q;
  assign err      = err_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed test-plan cases plus randomized accesses.
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        INT;
  logic [31:0] z, rd2, mrdata;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite, mack;
  logic [31:0] memOut, maddr, mwdata;
  logic        stall, err, misalign, mreq, mwe;
  logic [3:0]  mbe;

  int vectors = 0;
  int miscompares = 0;

  // Observations of one access, filled by apply_access.
  int          obs_stall, obs_req, obs_cycles;
  logic [31:0] obs_maddr, obs_mwdata, obs_memout;
  logic [3:0]  obs_mbe;
  logic        obs_mwe, obs_err, obs_mis, obs_unstable;
  logic        obs_err_after, obs_mis_after, obs_mreq_after;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk      (clk),
    .INT      (INT),
    .z        (z),
    .rd2      (rd2),
    .funct3   (funct3),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .memOut   (memOut),
    .stall    (stall),
    .err      (err),
    .misalign (misalign),
    .mreq     (mreq),
    .mwe      (mwe),
    .maddr    (maddr),
    .mwdata   (mwdata),
    .mbe      (mbe),
    .mrdata   (mrdata),
    .mack     (mack)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    int lo;
    n  = nbytes(f3);
    lo = int'(addr % 32'd4);
    if (n == 4) return 0;
    if (n == 2) return (lo / 2) * 2;
    return lo;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    int lo;
    n  = nbytes(f3);
    lo = int'(addr % 32'd4);
    return TrapEn && (((n == 2) && (lo % 2 != 0)) || ((n == 4) && (lo != 0)));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    int     n;
    longint span;
    longint v;
    n    = nbytes(f3);
    span = longint'(1) << (8 * n);
    v    = (longint'(word) >> (8 * lane_off(f3, addr))) % span;
    if ((f3[2] == 1'b0) && (n < 4) && (v >= span / 2)) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3,
                                      input logic [31:0] addr);
    int b;
    if (!st) return 4'hF;
    b = ((1 << nbytes(f3)) - 1) << lane_off(f3, addr);
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
    int     n;
    longint piece;
    longint r;
    n     = nbytes(f3);
    piece = longint'(data) % (longint'(1) << (8 * n));
    r     = 0;
    for (int i = 0; i < 4 / n; i++) r = r + (piece << (8 * n * i));
    return r[31:0];
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  // delay < 0: never acknowledge. Ends at the negedge of the following IDLE cycle.
  task automatic apply_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] word,
                              input int delay);
    bit done;
    done = 1'b0;
    obs_stall = 0; obs_req = 0; obs_cycles = 0; obs_unstable = 1'b0;
    obs_err = 1'b0; obs_mis = 1'b0; obs_memout = 32'd0;
    obs_maddr = 32'd0; obs_mwdata = 32'd0; obs_mbe = 4'd0; obs_mwe = 1'b0;
    MemRead = !st; MemWrite = st; z = addr; rd2 = data; funct3 = f3; mack = 1'b0;
    #1;
    for (int it = 0; it < 60 && !done; it++) begin
      if (it > 0) @(negedge clk);
      obs_cycles++;
      if (stall) obs_stall++;
      if (mreq) begin
        if (obs_req == 0) begin
          obs_maddr = maddr; obs_mwdata = mwdata; obs_mbe = mbe; obs_mwe = mwe;
        end else if (maddr !== obs_maddr || mwdata !== obs_mwdata || mbe !== obs_mbe ||
                     mwe !== obs_mwe) begin
          obs_unstable = 1'b1;
        end
        mack   = (delay >= 0) && (obs_req == delay);
        mrdata = mack ? word : $urandom();
        obs_req++;
      end else begin
        mack = 1'b0;
        if (!stall && it > 0) begin
          done = 1'b1;
          obs_memout = memOut; obs_err = err; obs_mis = misalign;
        end
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; mack = 1'b0;
    @(negedge clk);
    obs_err_after = err; obs_mis_after = misalign; obs_mreq_after = mreq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    INT = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; z = 32'h1234_5678; rd2 = 32'hFFFF_FFFF;
    funct3 = 3'b010; mack = 1'b1; mrdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++;
      $display("FAIL reset_stall: got %b want 0", stall); end
    vectors++; if ({mreq, mwe, err, misalign} !== 4'b0) begin miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {mreq, mwe, err, misalign}); end
    vectors++; if (maddr !== 32'd0 || mwdata !== 32'd0 || mbe !== 4'd0) begin miscompares++;
      $display("FAIL reset_port: got %h/%h/%h want 0", maddr, mwdata, mbe); end
    vectors++; if (memOut !== 32'd0) begin miscompares++;
      $display("FAIL reset_memout: got %h want 0", memOut); end
    INT = 1'b0; MemRead = 1'b0; mack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_stall();
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      z = $urandom(); funct3 = 3'($urandom_range(0, 7)); mack = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (stall !== 1'b0 || mreq !== 1'b0) begin miscompares++;
        $display("FAIL no_stall #%0d: got stall=%b mreq=%b want 0 0", i, stall, mreq); end
      @(negedge clk);
    end
    mack = 1'b0;
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] word;
    logic [3:0]  be;
    logic [31:0] val;
  } dvec_t;

  task automatic test_directed();
    dvec_t dv[5];
    dv[0] = '{1'b0, 3'b010, 32'h28, 32'h0,  32'h1234_5678, 4'hF, 32'h1234_5678};
    dv[1] = '{1'b1, 3'b000, 32'h2B, 32'hA5, 32'h0,         4'h8, 32'hA5A5_A5A5};
    dv[2] = '{1'b0, 3'b000, 32'h31, 32'h0,  32'h0000_8000, 4'hF, 32'hFFFF_FF80};
    dv[3] = '{1'b0, 3'b100, 32'h31, 32'h0,  32'h0000_8000, 4'hF, 32'h0000_0080};
    dv[4] = '{1'b0, 3'b001, 32'h32, 32'h0,  32'h8001_0000, 4'hF, 32'hFFFF_8001};
    for (int i = 0; i < 5; i++) begin
      apply_access(dv[i].st, dv[i].f3, dv[i].addr, dv[i].data, dv[i].word, 0);
      vectors++; if (obs_stall != 2) begin miscompares++;
        $display("FAIL dir_stall #%0d: got %0d want 2", i, obs_stall); end
      vectors++; if (obs_maddr !== {dv[i].addr[31:2], 2'b00}) begin miscompares++;
        $display("FAIL dir_maddr #%0d: got %h want %h", i, obs_maddr,
                 {dv[i].addr[31:2], 2'b00}); end
      vectors++; if (obs_mbe !== dv[i].be || obs_mwe !== dv[i].st) begin miscompares++;
        $display("FAIL dir_be_we #%0d: got %b/%b want %b/%b", i, obs_mbe, obs_mwe,
                 dv[i].be, dv[i].st); end
      vectors++;
      if ((dv[i].st ? obs_mwdata : obs_memout) !== dv[i].val) begin miscompares++;
        $display("FAIL dir_data #%0d: got %h want %h", i,
                 dv[i].st ? obs_mwdata : obs_memout, dv[i].val); end
    end
  endtask

  task automatic test_random();
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr, data, word, exp_mem;
    int          dly, exp_stall, exp_req;
    bit          mis;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = $urandom(); data = $urandom(); word = $urandom();
      dly = $urandom_range(0, 4);
      mis = m_misaligned(f3, addr);
      exp_stall = mis ? 1 : dly + 2;
      exp_req   = mis ? 0 : dly + 1;
      exp_mem   = mis ? 32'd0 : m_load(f3, addr, word);
      apply_access(st, f3, addr, data, word, dly);
      vectors++; if (obs_stall != exp_stall || obs_req != exp_req) begin miscompares++;
        $display("FAIL rnd_timing #%0d: got stall=%0d req=%0d want %0d %0d", i, obs_stall,
                 obs_req, exp_stall, exp_req); end
      vectors++; if (obs_mis !== mis || obs_err !== 1'b0 || obs_mis_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_flags #%0d: got mis=%b err=%b want %b 0", i, obs_mis, obs_err,
                 mis); end
      if (!mis) begin
        vectors++;
        if (obs_maddr !== {addr[31:2], 2'b00} || obs_mbe !== m_be(st, f3, addr) ||
            obs_mwe !== st || obs_unstable !== 1'b0) begin miscompares++;
          $display("FAIL rnd_port #%0d: got %h/%b/%b/%b want %h/%b/%b/0", i, obs_maddr,
                   obs_mbe, obs_mwe, obs_unstable, {addr[31:2], 2'b00}, m_be(st, f3, addr),
                   st); end
      end
      if (st && !mis) begin
        vectors++; if (obs_mwdata !== m_wdata(f3, data)) begin miscompares++;
          $display("FAIL rnd_wdata #%0d: got %h want %h", i, obs_mwdata, m_wdata(f3, data));
        end
      end
      if (!st || mis) begin
        vectors++; if (obs_memout !== exp_mem) begin miscompares++;
          $display("FAIL rnd_memout #%0d f3=%b addr=%h: got %h want %h", i, f3, addr,
                   obs_memout, exp_mem); end
      end
    end
  endtask

  task automatic test_timeout();
    apply_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    vectors++; if (obs_memout !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL to_preload: got %h want deadbeef", obs_memout); end
    apply_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, -1);
    vectors++; if (obs_req != 15 || obs_stall != 16) begin miscompares++;
      $display("FAIL to_cycles: got req=%0d stall=%0d want 15 16", obs_req, obs_stall); end
    vectors++; if (obs_err !== 1'b1 || obs_err_after !== 1'b0) begin miscompares++;
      $display("FAIL to_err: got %b then %b want 1 then 0", obs_err, obs_err_after); end
    vectors++; if (obs_memout !== 32'd0 || obs_mreq_after !== 1'b0) begin miscompares++;
      $display("FAIL to_memout: got %h mreq=%b want 0 0", obs_memout, obs_mreq_after); end
  endtask

  task automatic test_reset_mid_req();
    apply_access(1'b0, 3'b010, 32'h44, 32'h0, 32'h5A5A_1234, 1);
    vectors++; if (obs_memout !== 32'h5A5A_1234) begin miscompares++;
      $display("FAIL rst_preload: got %h want 5a5a1234", obs_memout); end
    MemRead = 1'b1; funct3 = 3'b010; z = 32'h40;
    @(negedge clk);
    vectors++; if (mreq !== 1'b1) begin miscompares++;
      $display("FAIL rst_inreq: got mreq=%b want 1", mreq); end
    INT = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    vectors++; if (mreq !== 1'b0 || stall !== 1'b0 || memOut !== 32'd0) begin miscompares++;
      $display("FAIL rst_abandon: got mreq=%b stall=%b memOut=%h want 0 0 0", mreq, stall,
               memOut); end
    INT = 1'b0; mack = 1'b1; mrdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (mreq !== 1'b0 || stall !== 1'b0 || memOut !== 32'd0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_late_ack #%0d: got mreq=%b stall=%b memOut=%h err=%b want 0", i,
                 mreq, stall, memOut, err); end
    end
    mack = 1'b0;
  endtask

  task automatic test_misalign();
    logic [31:0] exp_mem;
    int          exp_req;
    exp_req = TrapEn ? 0 : 1;
    exp_mem = TrapEn ? 32'd0 : 32'hCAFE_F00D;
    apply_access(1'b0, 3'b010, 32'h2A, 32'h0, 32'hCAFE_F00D, 0);
    vectors++; if (obs_req != exp_req || obs_mis !== TrapEn) begin miscompares++;
      $display("FAIL mis_req: got req=%0d mis=%b want %0d %b", obs_req, obs_mis, exp_req,
               TrapEn); end
    vectors++; if (obs_memout !== exp_mem || obs_mis_after !== 1'b0) begin miscompares++;
      $display("FAIL mis_memout: got %h after=%b want %h 0", obs_memout, obs_mis_after,
               exp_mem); end
    if (exp_req == 1) begin
      vectors++; if (obs_maddr !== 32'h28) begin miscompares++;
        $display("FAIL mis_maddr: got %h want 00000028", obs_maddr); end
    end
  endtask

  task automatic test_back_to_back();
    int          dly[3];
    logic [31:0] w;
    dly[0] = 0; dly[1] = 2; dly[2] = 1;
    for (int i = 0; i < 3; i++) begin
      w = $urandom();
      apply_access(1'b0, 3'b010, 32'h200 + 32'(4 * i), 32'h0, w, dly[i]);
      vectors++; if (obs_cycles != dly[i] + 3 || obs_memout !== w) begin miscompares++;
        $display("FAIL b2b #%0d: got cycles=%0d memOut=%h want %0d %h", i, obs_cycles,
                 obs_memout, dly[i] + 3, w); end
    end
  endtask

  initial begin
    INT = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; z = 32'd0; rd2 = 32'd0;
    funct3 = 3'd0; mack = 1'b0; mrdata = 32'd0;
    test_reset();
    test_no_stall();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid_req();
    test_misalign();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Multi-cycle data-memory access stage between the execute result (`z`, `rd2`) and write-back, replacing the ideal single-cycle data memory with a request/acknowledge port to a memory of variable latency. It decodes load/store width from `funct3`, generates word-aligned addresses with byte enables, and sign- or zero-extends load data. It holds the core via `stall` until each access completes.

## Interface
Parameters:
- `WAIT_MAX`, 15: cycles in REQ without `mack` before the access is abandoned with `err`.

Ports (one clock `clk`; reset `INT` is synchronous, active-high):
- `clk`  in  1  rising-edge clock
- `INT`  in  1  synchronous active-high reset
- `z`  in  32  effective address from EX
- `rd2`  in  32  store data
- `funct3`  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `MemRead`  in  1  load instruction present
- `MemWrite`  in  1  store instruction present
- `memOut`  out  32  extended load data, valid in DONE
- `stall`  out  1  core must not advance PC / write regs
- `err`  out  1  one-cycle pulse: access timed out
- `misalign`  out  1  one-cycle pulse: misaligned access (macro only)
- `mreq`  out  1  memory request
- `mwe`  out  1  write enable qualifying `mreq`
- `maddr`  out  32  `{z[31:2],2'b00}` captured
- `mwdata`  out  32  lane-replicated store data
- `mbe`  out  4  byte enables
- `mrdata`  in  32  memory read word
- `mack`  in  1  access complete, sampled at rising edge

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if `MemRead|MemWrite`, capture address/data/`funct3`/direction, go REQ. Else remain.
- REQ: `mreq`=1, `mwe`=captured write. On `mack`: loads register extended `mrdata` into `memOut`; go DONE. Wait counter increments each REQ cycle; reaching `WAIT_MAX` without `mack` → DONE, `err`=1, `memOut`=0.
- DONE: one cycle, `stall`=0, then IDLE.
- `stall` = (IDLE & (`MemRead|MemWrite`)) | REQ. Non-memory instructions never stall.
- Byte enables: B → `4'b0001 << z[1:0]`, data `{4{rd2[7:0]}}`; H → `4'b0011 << {z[1],1'b0}`, data `{2{rd2[15:0]}}`; W → `4'b1111`, data `rd2`. Loads: `mbe`=`4'b1111`.
- Load extension: lane selected by captured `z[1:0]`; B/H sign-extend, BU/HU zero-extend, W unchanged. Unused `funct3` codes (011,110,111) treated as W.
- `mack` in IDLE or DONE ignored.

## Timing
- Reset (`INT`=1 at edge): state IDLE, counter 0; `memOut`, `mreq`, `mwe`, `maddr`, `mwdata`, `mbe`, `err`, `misalign` all 0; `stall` forced 0 while `INT`=1.
- Minimum memory instruction: 3 cycles (IDLE stall, REQ with `mack`, DONE).
- `mreq` and captured address/data/enables stable throughout REQ; drop to 0 the cycle after `mack`.
- `err`/`misalign` asserted only during DONE.
- Reset in REQ: abandon access, `mreq` low next cycle; late `mack` ignored.
- Back-to-back memory instructions: DONE → IDLE → REQ; never overlap.

## Configuration
- `MEM_STAGE_MISALIGN_TRAP_EN` defined: H with `z[0]`=1 or W with `z[1:0]`≠0 issues no request; IDLE → DONE directly, `misalign`=1, `memOut`=0, memory untouched.
- Undefined: low address bits ignored for alignment (H uses `{z[1],1'b0}`, W uses lane 0); `misalign` tied 0.

## Structure
- Package `mem_stage_pkg`: state enum, `funct3` width constants, default `WAIT_MAX`.
- Sub-module `mem_lane_align`: combinational store-lane replication/byte enables and load lane select/extension; FSM and counter in top.

## Test plan
- LW `z`=0x28, memory returns 0x12345678 with `mack` in first REQ cycle → `maddr`=0x28, `mbe`=1111, `memOut`=0x12345678 in DONE, `stall` high exactly 2 cycles.
- SB `z`=0x2B, `rd2`=0xA5 → `mbe`=1000, `mwdata`=0xA5A5A5A5, `mwe`=1.
- LB `z`=0x31, word 0x0000_8000 → `memOut`=0xFFFFFF80; LBU → 0x00000080; LH `z`=0x32, word 0x8001_0000 → 0xFFFF8001.
- No `mack` for 15 cycles → DONE, `err`=1 one cycle, `memOut`=0, `mreq` low after.
- `INT` pulsed mid-REQ, then `mack` → outputs 0, state IDLE, `mack` ignored.
- With macro: LW `z`=0x2A → no `mreq`, `misalign`=1 next cycle; without macro: `maddr`=0x28, normal access.
